uart_cmd_rx: RTL



---
 rtl/uart_cmd_rx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with a frame assembler that builds a BYTES-wide command, MSB byte first,
// with an optional trailing checksum byte, an inter-byte timeout and framing-error reporting.
module uart_cmd_rx #(
    parameter int unsigned BYTES       = 2,
    parameter int unsigned BAUD_DIV    = 2604,
    parameter int unsigned TIMEOUT_CYC = 65536,
    parameter int unsigned CHKSUM_EN   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX,
    input  logic               clr_cmd_rdy,
    output logic [8*BYTES-1:0] cmd,
    output logic               cmd_rdy,
    output logic               chk_err,
    output logic               frm_err
);

    localparam int unsigned   FRAME_LEN = (CHKSUM_EN != 0) ? BYTES + 1 : BYTES;
    localparam int unsigned   CW        = $clog2(FRAME_LEN + 1);
    localparam int unsigned   BW        = $clog2(BAUD_DIV);
    localparam int unsigned   TW        = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned   SW        = 8 * BYTES;
    localparam logic [BW-1:0] HALF_M1   = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] FULL_M1   = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] PAY_LEN   = CW'(BYTES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam bit            CHK_ON    = (CHKSUM_EN != 0);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_prev;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_byte;
    logic [SW-1:0]   r_shift;
    logic [7:0]      r_sum;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmo;
    logic            r_done;
    logic [SW-1:0]   r_cmd;
    logic            r_cmd_rdy;
    logic            r_chk_err;
    logic            r_frm_err;

    logic            w_expire;
    logic            w_start_edge;
    logic            w_baud_load;
    logic [BW-1:0]   w_baud_val;
    logic            w_sample;
    logic            w_byte_ok;
    logic            w_frm_bad;
    logic            w_tmo_run;
    logic            w_timeout;
    logic            w_complete_ok;

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;
    assign chk_err = r_chk_err;
    assign frm_err = r_frm_err;

    // Baud counter holds remaining cycles minus one, so expiry is at zero.
    assign w_expire = (r_baud == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_edge = 1'b0;
        w_baud_load  = 1'b0;
        w_baud_val   = '0;
        w_sample     = 1'b0;
        w_byte_ok    = 1'b0;
        w_frm_bad    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_start_edge = 1'b1;
                    w_baud_load  = 1'b1;
                    w_baud_val   = HALF_M1;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_expire) begin
                    if (!r_rx_s2) begin
                        w_baud_load = 1'b1;
                        w_baud_val  = FULL_M1;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_expire) begin
                    w_sample    = 1'b1;
                    w_baud_load = 1'b1;
                    w_baud_val  = FULL_M1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_byte_ok   = r_rx_s2;
                    w_frm_bad   = !r_rx_s2;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_tmo_run     = (r_state == S_IDLE) && (r_cnt != '0) && !r_done;
    assign w_timeout     = w_tmo_run && !w_start_edge && (r_tmo == TMO_LAST);
    assign w_complete_ok = r_done && (!CHK_ON || (r_sum == 8'h00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_baud    <= '0;
            r_bitcnt  <= '0;
            r_byte    <= '0;
        end else begin
            r_rx_s1   <= RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (w_baud_load) begin
                r_baud <= w_baud_val;
            end else if (!w_expire) begin
                r_baud <= r_baud - BW'(1);
            end
            if (r_state == S_START) begin
                r_bitcnt <= '0;
            end else if (w_sample) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_sample) begin
                r_byte <= {r_rx_s2, r_byte[7:1]};
            end
        end
    end

    // Frame assembly: completion is evaluated the cycle after the last stop sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_done    <= 1'b0;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_chk_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_chk_err <= 1'b0;
            r_frm_err <= w_frm_bad;

            if (w_start_edge || !w_tmo_run || w_timeout) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end

            if (w_frm_bad) begin
                r_cnt <= '0;
                r_sum <= '0;
            end else if (w_byte_ok) begin
                if (r_cnt < PAY_LEN) begin
                    r_shift <= SW'({r_shift, r_byte});
                end
                r_sum <= r_sum + r_byte;
                if (r_cnt == LAST_IDX) begin
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (r_done) begin
                r_cnt <= '0;
                r_sum <= '0;
                if (w_complete_ok) begin
                    r_cmd <= r_shift;
                end else begin
                    r_chk_err <= 1'b1;
                end
            end else if (w_timeout) begin
                r_cnt <= '0;
                r_sum <= '0;
            end

            if (w_complete_ok) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || (w_start_edge && (r_cnt == '0))) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

endmodule
